// File: rtl/tlul_reg_responder.sv
// -----------------------------------------------------------------------------
// tlul_pkg + tlul_reg_responder
//
// Device-side TL-UL endpoint. Accepts A-channel requests from a crossbar port,
// backs NumRegs 32-bit software registers, exposes them to hardware, and
// returns D-channel responses through an in-order response FIFO of RspDepth
// entries so the host can pipeline requests.
//
// Ports
//   clk_i     clock
//   rst_i     synchronous reset, active-high
//   tl_i      A-channel request + d_ready            (tlul_pkg::tl_h2d_t)
//   tl_o      D-channel response + a_ready           (tlul_pkg::tl_d2h_t)
//   reg_q_o   register contents, reg k at [32k+31:32k]
//   reg_we_o  one-cycle pulse per register after a committed write
//
// Optional feature macro: TLUL_REG_LOCK_EN
//   Defined   : register NumRegs-1 is LOCK. Bit 0 is sticky once written 1
//               (cleared only by rst_i, resets to 0); bits 31:1 read 0. While
//               locked, Puts to offsets 0..NumRegs-2 return d_error=1.
//   Undefined : register NumRegs-1 is an ordinary register.
// -----------------------------------------------------------------------------

package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_reg_responder #(
  parameter int unsigned NumRegs  = 8,
  parameter int unsigned RspDepth = 2,
  parameter logic [31:0] ResetVal = 32'h0000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  tlul_pkg::tl_h2d_t       tl_i,
  output tlul_pkg::tl_d2h_t       tl_o,
  output logic [NumRegs*32-1:0]   reg_q_o,
  output logic [NumRegs-1:0]      reg_we_o
);

  import tlul_pkg::*;

  localparam int unsigned OffW = $clog2(NumRegs);
  localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CntW = $clog2(RspDepth + 1);
  localparam logic [OffW:0]     NumRegsW = (OffW + 1)'(NumRegs);
  localparam logic [PtrW-1:0]   LastPtr  = PtrW'(RspDepth - 1);
  localparam logic [CntW-1:0]   DepthW   = CntW'(RspDepth);

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
    logic        error;
  } rsp_t;

  logic [31:0]     regs_q [NumRegs];
  rsp_t            fifo_mem [RspDepth];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count;

  logic            a_ready, accept, pop;
  logic [OffW-1:0] offset;
  logic            is_get, is_put_full, is_put_part, is_put;
  logic            req_err, lock_err, write_en;
  logic [31:0]     wr_val;
  rsp_t            rsp_push;

  // Only the low address bits select a register; the crossbar already decoded
  // the base. The remaining bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^tl_i.a_address[31:OffW+2];

  assign offset      = tl_i.a_address[OffW+1:2];
  assign is_get      = (tl_i.a_opcode == Get);
  assign is_put_full = (tl_i.a_opcode == PutFullData);
  assign is_put_part = (tl_i.a_opcode == PutPartialData);
  assign is_put      = is_put_full | is_put_part;

  // No same-cycle pop bypass: a full FIFO stalls A even if D is draining.
  assign a_ready = !rst_i && (count < DepthW);
  assign accept  = tl_i.a_valid & a_ready;
  assign pop     = (count != '0) & tl_i.d_ready;

`ifdef TLUL_REG_LOCK_EN
  localparam logic [OffW-1:0] LockIdx = OffW'(NumRegs - 1);
  assign lock_err = is_put && regs_q[LockIdx][0] && (offset != LockIdx);
`else
  assign lock_err = 1'b0;
`endif

  assign req_err = (tl_i.a_address[1:0] != 2'b00)
                 | (tl_i.a_size != 2'd2)
                 | (tl_i.a_param != 3'd0)
                 | !(is_get | is_put)
                 | (is_put_full & (tl_i.a_mask != 4'hF))
                 | ({1'b0, offset} >= NumRegsW)
                 | lock_err;

  // A partial put with an empty mask is acknowledged but commits nothing.
  assign write_en = accept & !req_err & is_put & (|tl_i.a_mask);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    wr_val = regs_q[offset];
    for (int b = 0; b < 4; b++) begin
      if (tl_i.a_mask[b]) wr_val[8*b +: 8] = tl_i.a_data[8*b +: 8];
    end
`ifdef TLUL_REG_LOCK_EN
    // LOCK keeps only bit 0, and once set it cannot be cleared by software.
    if (offset == LockIdx) wr_val = {31'b0, regs_q[LockIdx][0] | wr_val[0]};
`endif
  end

  always_comb begin
    rsp_push        = '0;
    rsp_push.opcode = is_get ? AccessAckData : AccessAck;
    rsp_push.size   = tl_i.a_size;
    rsp_push.source = tl_i.a_source;
    rsp_push.error  = req_err;
    // Read value is the pre-write register contents at the accept edge.
    rsp_push.data   = (is_get && !req_err) ? regs_q[offset] : 32'h0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumRegs; k++) regs_q[k] <= ResetVal;
`ifdef TLUL_REG_LOCK_EN
      regs_q[NumRegs-1] <= 32'h0;
`endif
      reg_we_o <= '0;
    end else begin
      reg_we_o <= '0;
      if (write_en) begin
        regs_q[offset]   <= wr_val;
        reg_we_o[offset] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
      if (pop)    rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
      count <= count + CntW'(accept) - CntW'(pop);
    end
  end

  // NOTE: the FIFO payload storage has no reset; an entry is only visible
  // through count, which is reset, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (accept) fifo_mem[wr_ptr] <= rsp_push;
  end

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = a_ready;
    tl_o.d_valid  = (count != '0);
    tl_o.d_opcode = fifo_mem[rd_ptr].opcode;
    tl_o.d_size   = fifo_mem[rd_ptr].size;
    tl_o.d_source = fifo_mem[rd_ptr].source;
    tl_o.d_data   = fifo_mem[rd_ptr].data;
    tl_o.d_error  = fifo_mem[rd_ptr].error;
  end

  for (genvar k = 0; k < NumRegs; k++) begin : g_reg_q
    assign reg_q_o[32*k +: 32] = regs_q[k];
  end

endmodule

// File: tb/tb_tlul_reg_responder.sv
`timescale 1ns/1ps
module tb_tlul_reg_responder;
  import tlul_pkg::*;

  localparam int          NR    = 8;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            rst;
  tl_h2d_t         tl_i;
  tl_d2h_t         tl_o;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0]   reg_we;

  always #5 clk = ~clk;

  tlul_reg_responder #(.NumRegs(NR), .RspDepth(DEPTH), .ResetVal(RV)) dut (
    .clk_i(clk), .rst_i(rst), .tl_i(tl_i), .tl_o(tl_o),
    .reg_q_o(reg_q), .reg_we_o(reg_we)
  );

  typedef struct packed {
    logic        vld;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
    logic        side;   // OR of d_param/d_sink/d_user, always expected 0
  } rsp_t;

  int checks = 0;
  int errors = 0;

  // Reference model: register array plus the list of responses owed.
  logic [31:0] mregs [NR];
  rsp_t        mq[$];
  rsp_t        exp_log[$];
  rsp_t        obs_log[$];
  logic [NR-1:0] exp_we;
  int rdy_bad, dv_bad, we_bad;
  int we_seen [NR];

  function automatic void model_reset();
    for (int k = 0; k < NR; k++) mregs[k] = RV;
`ifdef TLUL_REG_LOCK_EN
    mregs[NR-1] = 32'h0;
`endif
    mq.delete();
    exp_we = '0;
  endfunction

  function automatic void model_req(output rsp_t r, output bit we,
                                    output int off, output logic [31:0] nv);
    bit err;
    int op;
    op  = int'(tl_i.a_opcode);
    off = int'((tl_i.a_address >> 2) % NR);
    err = (tl_i.a_address[1:0] != 0) || (tl_i.a_size != 2) || (tl_i.a_param != 0) ||
          !(op == 0 || op == 1 || op == 4) || (op == 0 && tl_i.a_mask != 4'hF);
`ifdef TLUL_REG_LOCK_EN
    if (op != 4 && off != NR-1 && mregs[NR-1][0]) err = 1;
`endif
    r      = '0;
    r.vld  = 1'b1;
    r.op   = (op == 4) ? 3'd1 : 3'd0;
    r.size = tl_i.a_size;
    r.src  = tl_i.a_source;
    r.err  = err;
    r.data = (!err && op == 4) ? mregs[off] : 32'h0;
    we     = !err && op != 4 && tl_i.a_mask != 0;
    nv     = mregs[off];
    for (int b = 0; b < 4; b++)
      if (tl_i.a_mask[b]) nv[8*b +: 8] = tl_i.a_data[8*b +: 8];
`ifdef TLUL_REG_LOCK_EN
    if (off == NR-1) nv = {31'b0, mregs[off][0] | (tl_i.a_mask[0] & tl_i.a_data[0])};
`endif
  endfunction

  // Advance one clock from a negedge to the next negedge, updating the model
  // and recording what the DUT did for the tests to judge.
  task automatic step();
    bit exp_rdy, acc, pop, we;
    rsp_t r, o;
    int off;
    logic [31:0] nv;
    #1;
    exp_rdy = !rst && (mq.size() < DEPTH);
    if (tl_o.a_ready !== exp_rdy) rdy_bad++;
    if (tl_o.d_valid !== (mq.size() > 0)) dv_bad++;
    pop = !rst && tl_i.d_ready && (mq.size() > 0);
    if (!rst && ((tl_o.d_valid === 1'b1 && tl_i.d_ready) || pop)) begin
      exp_log.push_back(pop ? mq[0] : rsp_t'(0));
      o = '0;
      if (tl_o.d_valid === 1'b1 && tl_i.d_ready) begin
        o.vld  = 1'b1;
        o.op   = tl_o.d_opcode;
        o.size = tl_o.d_size;
        o.src  = tl_o.d_source;
        o.data = tl_o.d_data;
        o.err  = tl_o.d_error;
        o.side = |{tl_o.d_param, tl_o.d_sink, tl_o.d_user};
      end
      obs_log.push_back(o);
    end
    acc = tl_i.a_valid && exp_rdy;
    r = '0; we = 0; off = 0; nv = '0;
    if (acc) model_req(r, we, off, nv);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(r);
        if (we) mregs[off] = nv;
      end
      exp_we = (acc && we) ? NR'(1) << off : '0;
    end
    @(negedge clk);
    if (reg_we !== exp_we) we_bad++;
    for (int k = 0; k < NR; k++) if (reg_we[k] === 1'b1) we_seen[k]++;
  endtask

  task automatic set_req(input logic [2:0] op, input int off, input logic [3:0] mask,
                         input logic [31:0] data, input logic [7:0] src);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_param   = 3'd0;
    tl_i.a_size    = 2'd2;
    tl_i.a_source  = src;
    tl_i.a_address = ($urandom << 5) | 32'(off << 2);
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
  endtask

  task automatic idle();
    tl_i.a_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    tl_i.d_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && mq.size() > 0; i++) step();
    step();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    tl_i = '0;
    tl_i.a_valid = 1'b1;
    tl_i.d_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tl_o.d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid got %b want 0", tl_o.d_valid); end
    checks++;
    if (tl_o.a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready got %b want 0", tl_o.a_ready); end
    checks++;
    if (reg_we !== '0) begin errors++; $display("FAIL reset_reg_we got %h want 0", reg_we); end
    checks++;
    if (reg_q !== {NR{RV}}) begin errors++; $display("FAIL reset_reg_q got %h want %h", reg_q, {NR{RV}}); end
    model_reset();
    idle();
    rst = 1'b0;
    for (int k = 0; k < NR; k++) we_seen[k] = 0;
  endtask

  task automatic test_put_get();
    int base = exp_log.size();
    rdy_bad = 0; dv_bad = 0; we_bad = 0;
    tl_i.d_ready = 1'b0;
    set_req(3'h0, 1, 4'hF, 32'hDEAD_BEEF, 8'h11);
    step();
    idle();
    checks++;
    if (tl_o.d_valid !== 1'b1) begin errors++; $display("FAIL put_latency d_valid got %b want 1", tl_o.d_valid); end
    checks++;
    if (reg_q[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL put_reg1 got %h want deadbeef", reg_q[63:32]); end
    tl_i.d_ready = 1'b1;
    step();
    set_req(3'h4, 1, 4'hF, $urandom, 8'h22);
    step();
    drain();
    checks++;
    if (obs_log[obs_log.size()-1].data !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL get_reg1 got %h want deadbeef", obs_log[obs_log.size()-1].data); end
    for (int i = base; i < exp_log.size(); i++) begin
      checks++;
      if (obs_log[i] !== exp_log[i]) begin errors++; $display("FAIL put_get rsp%0d got %h want %h", i, obs_log[i], exp_log[i]); end
    end
    checks++;
    if (rdy_bad + dv_bad + we_bad != 0)
      begin errors++; $display("FAIL put_get handshake ready_bad %0d valid_bad %0d we_bad %0d want 0", rdy_bad, dv_bad, we_bad); end
  endtask

  task automatic test_partial();
    int base = exp_log.size();
    rdy_bad = 0; dv_bad = 0; we_bad = 0;
    tl_i.d_ready = 1'b1;
    set_req(3'h0, 2, 4'hF, 32'h1122_3344, 8'h01);
    step();
    idle();
    step();
    we_seen[2] = 0;
    set_req(3'h1, 2, 4'b0101, 32'hAABB_CCDD, 8'h02);
    step();
    idle();
    step();
    checks++;
    if (reg_q[95:64] !== 32'h11BB_33DD) begin errors++; $display("FAIL partial_reg2 got %h want 11bb33dd", reg_q[95:64]); end
    checks++;
    if (we_seen[2] != 1) begin errors++; $display("FAIL partial_we_pulses got %0d want 1", we_seen[2]); end
    set_req(3'h1, 2, 4'h0, $urandom, 8'h03);
    step();
    drain();
    checks++;
    if (we_seen[2] != 1) begin errors++; $display("FAIL mask0_we_pulses got %0d want 1", we_seen[2]); end
    checks++;
    if (reg_q[95:64] !== 32'h11BB_33DD) begin errors++; $display("FAIL mask0_reg2 got %h want 11bb33dd", reg_q[95:64]); end
    for (int i = base; i < exp_log.size(); i++) begin
      checks++;
      if (obs_log[i] !== exp_log[i]) begin errors++; $display("FAIL partial rsp%0d got %h want %h", i, obs_log[i], exp_log[i]); end
    end
    checks++;
    if (rdy_bad + dv_bad + we_bad != 0)
      begin errors++; $display("FAIL partial handshake ready_bad %0d valid_bad %0d we_bad %0d want 0", rdy_bad, dv_bad, we_bad); end
  endtask

  task automatic test_errors();
    int base = exp_log.size();
    logic [NR*32-1:0] snap = reg_q;
    rdy_bad = 0; dv_bad = 0; we_bad = 0;
    tl_i.d_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      case (t)
        0: begin set_req(3'h4, 3, 4'hF, 0, 8'h5A); tl_i.a_address[1:0] = 2'b10; end
        1: set_req(3'h0, 4, 4'h7, $urandom, 8'h61);
        2: begin set_req(3'h0, 5, 4'hF, $urandom, 8'h62); tl_i.a_size = 2'd1; end
        3: begin set_req(3'h1, 6, 4'hF, $urandom, 8'h63); tl_i.a_param = 3'd3; end
        4: set_req(3'h2, 1, 4'hF, $urandom, 8'h64);
        5: set_req(3'h7, 2, 4'hF, $urandom, 8'h65);
        default: begin set_req(3'h1, 0, 4'hF, $urandom, 8'h66); tl_i.a_address[0] = 1'b1; end
      endcase
      step();
      idle();
      step();
    end
    drain();
    checks++;
    if (obs_log[base].err !== 1'b1 || obs_log[base].data !== 32'h0 || obs_log[base].src !== 8'h5A)
      begin errors++; $display("FAIL misaligned_get got err %b data %h src %h want 1 0 5a",
                               obs_log[base].err, obs_log[base].data, obs_log[base].src); end
    checks++;
    if (reg_q !== snap) begin errors++; $display("FAIL error_regs_changed got %h want %h", reg_q, snap); end
    for (int i = base; i < exp_log.size(); i++) begin
      checks++;
      if (obs_log[i] !== exp_log[i]) begin errors++; $display("FAIL errors rsp%0d got %h want %h", i, obs_log[i], exp_log[i]); end
    end
    checks++;
    if (rdy_bad + dv_bad + we_bad != 0)
      begin errors++; $display("FAIL errors handshake ready_bad %0d valid_bad %0d we_bad %0d want 0", rdy_bad, dv_bad, we_bad); end
  endtask

  task automatic test_backpressure();
    int base = exp_log.size();
    tl_d2h_t held;
    rdy_bad = 0; dv_bad = 0; we_bad = 0;
    tl_i.d_ready = 1'b0;
    set_req(3'h0, 3, 4'hF, 32'h3333_0003, 8'hA1);
    step();
    set_req(3'h4, 3, 4'hF, $urandom, 8'hA2);
    step();
    set_req(3'h4, 2, 4'hF, $urandom, 8'hA3);
    checks++;
    if (tl_o.a_ready !== 1'b0) begin errors++; $display("FAIL full_a_ready got %b want 0", tl_o.a_ready); end
    held = tl_o;
    step();
    checks++;
    if (tl_o.d_valid !== 1'b1 || tl_o.d_source !== held.d_source || tl_o.d_data !== held.d_data ||
        tl_o.d_opcode !== held.d_opcode || tl_o.d_error !== held.d_error)
      begin errors++; $display("FAIL d_hold got src %h data %h want src %h data %h",
                               tl_o.d_source, tl_o.d_data, held.d_source, held.d_data); end
    tl_i.d_ready = 1'b1;
    step();
    checks++;
    if (tl_o.a_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop got %b want 1", tl_o.a_ready); end
    step();
    drain();
    checks++;
    if (obs_log[base].src !== 8'hA1 || obs_log[base+1].src !== 8'hA2 || obs_log[base+2].src !== 8'hA3)
      begin errors++; $display("FAIL order got %h %h %h want a1 a2 a3",
                               obs_log[base].src, obs_log[base+1].src, obs_log[base+2].src); end
    for (int i = base; i < exp_log.size(); i++) begin
      checks++;
      if (obs_log[i] !== exp_log[i]) begin errors++; $display("FAIL backpressure rsp%0d got %h want %h", i, obs_log[i], exp_log[i]); end
    end
    checks++;
    if (rdy_bad + dv_bad + we_bad != 0)
      begin errors++; $display("FAIL backpressure handshake ready_bad %0d valid_bad %0d we_bad %0d want 0", rdy_bad, dv_bad, we_bad); end
  endtask

  task automatic test_back_to_back();
    int base = exp_log.size();
    int not_ready = 0;
    rdy_bad = 0; dv_bad = 0; we_bad = 0;
    tl_i.d_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_req(($urandom_range(0, 1) != 0) ? 3'h4 : 3'h0, int'($urandom_range(0, NR-1)),
              4'hF, $urandom, 8'(i));
      #1;
      if (tl_o.a_ready !== 1'b1) not_ready++;
      step();
    end
    drain();
    checks++;
    if (not_ready != 0) begin errors++; $display("FAIL b2b_stalls got %0d want 0", not_ready); end
    checks++;
    if (exp_log.size() - base != 16) begin errors++; $display("FAIL b2b_count got %0d want 16", exp_log.size() - base); end
    for (int i = base; i < exp_log.size(); i++) begin
      checks++;
      if (obs_log[i] !== exp_log[i]) begin errors++; $display("FAIL b2b rsp%0d got %h want %h", i, obs_log[i], exp_log[i]); end
    end
    checks++;
    if (rdy_bad + dv_bad + we_bad != 0)
      begin errors++; $display("FAIL b2b handshake ready_bad %0d valid_bad %0d we_bad %0d want 0", rdy_bad, dv_bad, we_bad); end
  endtask

  task automatic test_random();
    int base = exp_log.size();
    int bad = 0;
    int sel;
    rdy_bad = 0; dv_bad = 0; we_bad = 0;
    for (int c = 0; c < 400; c++) begin
      tl_i.d_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        sel = int'($urandom_range(0, 9));
        set_req(sel < 4 ? 3'h4 : sel < 7 ? 3'h0 : sel < 9 ? 3'h1 : 3'($urandom),
                int'($urandom_range(0, NR-1)),
                (sel >= 4 && sel < 7 && $urandom_range(0, 7) != 0) ? 4'hF : 4'($urandom),
                $urandom, 8'($urandom));
        if ($urandom_range(0, 9) == 0) tl_i.a_address[1:0] = 2'($urandom);
        if ($urandom_range(0, 15) == 0) tl_i.a_size = 2'($urandom);
      end else idle();
      step();
    end
    drain();
    for (int k = 0; k < NR; k++) if (reg_q[32*k +: 32] !== mregs[k]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL random_regs got %0d differing want 0", bad); end
    for (int i = base; i < exp_log.size(); i++) begin
      checks++;
      if (obs_log[i] !== exp_log[i]) begin errors++; $display("FAIL random rsp%0d got %h want %h", i, obs_log[i], exp_log[i]); end
    end
    checks++;
    if (rdy_bad + dv_bad + we_bad != 0)
      begin errors++; $display("FAIL random handshake ready_bad %0d valid_bad %0d we_bad %0d want 0", rdy_bad, dv_bad, we_bad); end
  endtask

  task automatic test_reset_mid();
    int base = exp_log.size();
    rdy_bad = 0; dv_bad = 0; we_bad = 0;
    tl_i.d_ready = 1'b0;
    set_req(3'h0, 5, 4'hF, 32'h5555_AAAA, 8'hC1);
    step();
    set_req(3'h4, 5, 4'hF, $urandom, 8'hC2);
    step();
    idle();
    rst = 1'b1;
    step();
    checks++;
    if (tl_o.d_valid !== 1'b0) begin errors++; $display("FAIL midreset_d_valid got %b want 0", tl_o.d_valid); end
    checks++;
    if (reg_q !== {NR{RV}}) begin errors++; $display("FAIL midreset_regs got %h want %h", reg_q, {NR{RV}}); end
    rst = 1'b0;
    tl_i.d_ready = 1'b1;
    repeat (4) step();
    checks++;
    if (obs_log.size() != base) begin errors++; $display("FAIL stale_rsp got %0d responses want 0", obs_log.size() - base); end
    checks++;
    if (rdy_bad + dv_bad + we_bad != 0)
      begin errors++; $display("FAIL midreset handshake ready_bad %0d valid_bad %0d we_bad %0d want 0", rdy_bad, dv_bad, we_bad); end
  endtask

`ifdef TLUL_REG_LOCK_EN
  task automatic test_lock();
    int base = exp_log.size();
    rdy_bad = 0; dv_bad = 0; we_bad = 0;
    tl_i.d_ready = 1'b1;
    set_req(3'h0, NR-1, 4'hF, 32'h0000_0001, 8'hE0);
    step();
    set_req(3'h0, 0, 4'hF, 32'h0000_0001, 8'hE1);
    step();
    set_req(3'h4, 0, 4'hF, $urandom, 8'hE2);
    step();
    set_req(3'h0, NR-1, 4'hF, 32'hFFFF_FFFE, 8'hE3);
    step();
    drain();
    checks++;
    if (obs_log[base+1].err !== 1'b1) begin errors++; $display("FAIL locked_put err got %b want 1", obs_log[base+1].err); end
    checks++;
    if (reg_q[31:0] !== 32'h0) begin errors++; $display("FAIL locked_reg0 got %h want 0", reg_q[31:0]); end
    checks++;
    if (obs_log[base+2].err !== 1'b0 || obs_log[base+2].data !== 32'h0)
      begin errors++; $display("FAIL locked_get got err %b data %h want 0 0", obs_log[base+2].err, obs_log[base+2].data); end
    checks++;
    if (reg_q[32*(NR-1) +: 32] !== 32'h1) begin errors++; $display("FAIL lock_sticky got %h want 1", reg_q[32*(NR-1) +: 32]); end
    for (int i = base; i < exp_log.size(); i++) begin
      checks++;
      if (obs_log[i] !== exp_log[i]) begin errors++; $display("FAIL lock rsp%0d got %h want %h", i, obs_log[i], exp_log[i]); end
    end
    checks++;
    if (rdy_bad + dv_bad + we_bad != 0)
      begin errors++; $display("FAIL lock handshake ready_bad %0d valid_bad %0d we_bad %0d want 0", rdy_bad, dv_bad, we_bad); end
  endtask
`endif

  initial begin
    test_reset();
    test_put_get();
    test_partial();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef TLUL_REG_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
